bcd_count_2digit: RTL and testbench

Two-digit BCD counter that generates the units and tens digits driving the seven-segment digit decoders. Counts up or down through a programmable modulus, advancing once every DIV enabled clock cycles through an internal prescaler. Supports synchronous clear and parallel load. Flags wrap-around with a one-cycle carry pulse. The `units` output connects directly to `units_decoder`, and `tens` feeds the matching tens-digit decoder.

---
 rtl/bcd_count_2digit.sv | 115 +++++++++++
 tb/tb_bcd_count_2digit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_count_2digit.sv
// Two-digit BCD up/down counter with prescaler, programmable modulus, clear/load and step/carry pulses.
// Count/pulse outputs are registered and update on the step edge; zero is combinational; en stalls it, with no backpressure.
module bcd_count_2digit #(
    parameter int DIV    = 1,
    parameter int MODULO = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_units,
    input  logic       en,
    input  logic       up,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic       step,
    output logic       carry,
    output logic       zero
);

    localparam logic [3:0]  MAX_TENS  = 4'((MODULO - 1) / 10);
    localparam logic [3:0]  MAX_UNITS = 4'((MODULO - 1) % 10);
    localparam logic [15:0] PRE_LAST  = 16'(DIV - 1);

    logic [3:0]  units_q, units_d;
    logic [3:0]  tens_q, tens_d;
    logic [15:0] pre_q, pre_d;
    logic        step_q, step_d;
    logic        carry_q, carry_d;
    logic [3:0]  ld_tens, ld_units;
    logic        at_max, at_zero;

    assign at_max  = (tens_q == MAX_TENS) && (units_q == MAX_UNITS);
    assign at_zero = (tens_q == 4'd0) && (units_q == 4'd0);

    always_comb begin
        units_d  = units_q;
        tens_d   = tens_q;
        pre_d    = pre_q;
        step_d   = 1'b0;
        carry_d  = 1'b0;
        ld_tens  = (load_tens  > 4'd9) ? 4'd9 : load_tens;
        ld_units = (load_units > 4'd9) ? 4'd9 : load_units;

        if (clear) begin
            units_d = 4'd0;
            tens_d  = 4'd0;
            pre_d   = 16'd0;
        end else if (load) begin
            pre_d = 16'd0;
            // Digit-wise ">= MODULO" test against the split MODULO-1 constants.
            if ((ld_tens > MAX_TENS) || ((ld_tens == MAX_TENS) && (ld_units > MAX_UNITS))) begin
                tens_d  = MAX_TENS;
                units_d = MAX_UNITS;
            end else begin
                tens_d  = ld_tens;
                units_d = ld_units;
            end
        end else if (en) begin
            if (pre_q == PRE_LAST) begin
                pre_d  = 16'd0;
                step_d = 1'b1;
                if (up) begin
                    if (at_max) begin
                        units_d = 4'd0;
                        tens_d  = 4'd0;
                        carry_d = 1'b1;
                    end else if (units_q < 4'd9) begin
                        units_d = units_q + 4'd1;
                    end else begin
                        units_d = 4'd0;
                        tens_d  = tens_q + 4'd1;
                    end
                end else begin
                    if (at_zero) begin
                        units_d = MAX_UNITS;
                        tens_d  = MAX_TENS;
                        carry_d = 1'b1;
                    end else if (units_q > 4'd0) begin
                        units_d = units_q - 4'd1;
                    end else begin
                        units_d = 4'd9;
                        tens_d  = tens_q - 4'd1;
                    end
                end
            end else begin
                pre_d = pre_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            units_q <= 4'd0;
            tens_q  <= 4'd0;
            pre_q   <= 16'd0;
            step_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            units_q <= units_d;
            tens_q  <= tens_d;
            pre_q   <= pre_d;
            step_q  <= step_d;
            carry_q <= carry_d;
        end
    end

    assign units = units_q;
    assign tens  = tens_q;
    assign step  = step_q;
    assign carry = carry_q;
    assign zero  = at_zero;

endmodule

// File: tb/tb_bcd_count_2digit.sv
// Directed bench for bcd_count_2digit across three parameter sets sharing one stimulus stream.
// Expected outputs are queued with the stimulus and checked one time unit after each rising edge.
module tb_bcd_count_2digit;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
        logic       step;
        logic       carry;
        logic       zero;
    } obs_t;

    typedef struct {
        int    inst;
        string tag;
        obs_t  exp;
    } sb_t;

    logic       clk = 1'b0;
    logic       reset, clear, load, en, up;
    logic [3:0] load_tens, load_units;
    logic [3:0] units_w [3];
    logic [3:0] tens_w  [3];
    logic       step_w  [3];
    logic       carry_w [3];
    logic       zero_w  [3];

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    always #5 clk = ~clk;

    // inst 0: DIV=1 MODULO=100, inst 1: DIV=1 MODULO=60, inst 2: DIV=4 MODULO=100
    bcd_count_2digit #(.DIV(1), .MODULO(100)) u_a (
        .clk(clk), .reset(reset), .clear(clear), .load(load),
        .load_tens(load_tens), .load_units(load_units), .en(en), .up(up),
        .units(units_w[0]), .tens(tens_w[0]), .step(step_w[0]),
        .carry(carry_w[0]), .zero(zero_w[0])
    );
    bcd_count_2digit #(.DIV(1), .MODULO(60)) u_b (
        .clk(clk), .reset(reset), .clear(clear), .load(load),
        .load_tens(load_tens), .load_units(load_units), .en(en), .up(up),
        .units(units_w[1]), .tens(tens_w[1]), .step(step_w[1]),
        .carry(carry_w[1]), .zero(zero_w[1])
    );
    bcd_count_2digit #(.DIV(4), .MODULO(100)) u_c (
        .clk(clk), .reset(reset), .clear(clear), .load(load),
        .load_tens(load_tens), .load_units(load_units), .en(en), .up(up),
        .units(units_w[2]), .tens(tens_w[2]), .step(step_w[2]),
        .carry(carry_w[2]), .zero(zero_w[2])
    );

    function automatic obs_t mk(int t, int u, bit st, bit ca);
        obs_t o;
        o.tens  = 4'(t);
        o.units = 4'(u);
        o.step  = st;
        o.carry = ca;
        o.zero  = (t == 0) && (u == 0);
        return o;
    endfunction

    function automatic obs_t obs_of(int inst);
        obs_t o;
        o.tens  = tens_w[inst];
        o.units = units_w[inst];
        o.step  = step_w[inst];
        o.carry = carry_w[inst];
        o.zero  = zero_w[inst];
        return o;
    endfunction

    task automatic push(int inst, string tag, int t, int u, bit st, bit ca);
        sb_t e;
        e.inst = inst;
        e.tag  = tag;
        e.exp  = mk(t, u, st, ca);
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_t  e;
        obs_t o;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = obs_of(e.inst);
            n_cmp++;
            assert (o === e.exp) else begin
                n_bad++;
                $error("FAIL %s inst%0d: observed tens=%0d units=%0d step=%b carry=%b zero=%b, expected tens=%0d units=%0d step=%b carry=%b zero=%b",
                       e.tag, e.inst, o.tens, o.units, o.step, o.carry, o.zero,
                       e.exp.tens, e.exp.units, e.exp.step, e.exp.carry, e.exp.zero);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic do_load(int t, int u);
        clear      = 1'b0;
        load       = 1'b1;
        en         = 1'b0;
        load_tens  = 4'(t);
        load_units = 4'(u);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        reset = 1'b1; clear = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1;
        load_tens = 4'd0; load_units = 4'd0;
        #12;
        for (int i = 0; i < 3; i++) push(i, "reset_state", 0, 0, 0, 0);
        drain();
        reset = 1'b0;

        // Asynchronous reset mid-count, also mid-prescale for the DIV=4 instance
        do_load(4, 6);
        push(0, "load46", 4, 6, 0, 0);
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        push(0, "count47", 4, 7, 1, 0);
        tick();
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) push(i, "async_reset", 0, 0, 0, 0);
        drain();
        #1 reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            push(2, "reset_prescale", 0, (k == 4) ? 1 : 0, k == 4, 0);
            push(0, "post_reset_cnt", 0, k, 1, 0);
            tick();
        end

        // Up wrap at MODULO-1
        do_load(9, 8);
        push(0, "load98", 9, 8, 0, 0);
        push(1, "load98_m60", 5, 9, 0, 0);
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        push(0, "wrap99", 9, 9, 1, 0);
        push(1, "wrap_m60", 0, 0, 1, 1);
        tick();
        push(0, "wrap00", 0, 0, 1, 1);
        tick();
        push(0, "wrap01", 0, 1, 1, 0);
        tick();

        // Load clamping
        do_load(12, 15);
        push(0, "clamp_m100", 9, 9, 0, 0);
        push(1, "clamp_m60", 5, 9, 0, 0);
        push(2, "clamp_div4", 9, 9, 0, 0);
        tick();

        // Down wrap from 00
        do_load(0, 0);
        push(1, "load00_m60", 0, 0, 0, 0);
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0;
        push(1, "down_wrap_m60", 5, 9, 1, 1);
        push(0, "down_wrap_m100", 9, 9, 1, 1);
        tick();
        for (int k = 1; k <= 10; k++) begin
            v = 59 - k;
            push(1, "down_m60", v / 10, v % 10, 1, 0);
            tick();
        end

        // Prescaler, continuous enable
        do_load(0, 0);
        push(2, "pre_load00", 0, 0, 0, 0);
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            push(2, "prescale", 0, e / 4, (e % 4) == 0, 0);
            tick();
        end

        // Prescaler paused by en for edges 7..11
        do_load(0, 0);
        push(2, "pause_load00", 0, 0, 0, 0);
        tick();
        load = 1'b0; en = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            push(2, "pause_run", 0, (e >= 4) ? 1 : 0, e == 4, 0);
            tick();
        end
        en = 1'b0;
        for (int e = 7; e <= 11; e++) begin
            push(2, "pause_hold", 0, 1, 0, 0);
            tick();
        end
        en = 1'b1;
        push(2, "pause_e12", 0, 1, 0, 0);
        tick();
        push(2, "pause_e13", 0, 2, 1, 0);
        tick();

        // Priority: clear > load > count
        do_load(3, 7);
        push(0, "load37", 3, 7, 0, 0);
        tick();
        clear = 1'b1; load = 1'b1; load_tens = 4'd2; load_units = 4'd0; en = 1'b1; up = 1'b1;
        push(0, "clear_wins", 0, 0, 0, 0);
        tick();
        do_load(3, 7);
        push(0, "reload37", 3, 7, 0, 0);
        tick();
        load = 1'b1; load_tens = 4'd2; load_units = 4'd0; en = 1'b1;
        push(0, "load_wins", 2, 0, 0, 0);
        tick();
        load = 1'b0; en = 1'b0;
        push(0, "load_no_pulse", 2, 0, 0, 0);
        tick();
        en = 1'b1;
        push(0, "after_load", 2, 1, 1, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
